// File: rtl/tether_frame_tx.sv
// Buffers one RMII dibit burst, then emits it as a full Ethernet II frame (preamble, header, padded payload, FCS).
// Output is combinational from registered state; axiov rises the cycle after the burst ends.
module tether_frame_tx #(
  parameter logic [47:0] DEST_MAC          = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC           = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5,
  parameter int          MAX_PAYLOAD_BYTES = 64,
  parameter int          IFG_CYCLES        = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod
);

  localparam int CW = 16;
  localparam int AW = $clog2(MAX_PAYLOAD_BYTES);
  localparam logic [CW-1:0]  MAX_DIBITS = CW'(MAX_PAYLOAD_BYTES * 4);
  localparam logic [CW-1:0]  MIN_PAY    = CW'(46);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(IFG_CYCLES - 1);
  localparam logic [111:0]   HDR        = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]    CRC_POLY   = 32'hEDB88320;

  typedef enum logic [2:0] {IDLE, COLLECT, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, GAP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    pay_buf [MAX_PAYLOAD_BYTES];
  logic [CW-1:0] dcnt, cnt, nbytes, sec_last;
  logic [1:0]    dib;
  logic [31:0]   crc, crc_out;
  logic [7:0]    cur_byte;
  logic [3:0]    hidx;
  logic          byte_end, sec_end, buf_we;

  // Reflected CRC-32, two bits per call, bit 0 of the dibit first.
  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  assign nbytes   = (dcnt + CW'(3)) >> 2;
  assign hidx     = cnt[3:0];
  assign crc_out  = ~crc;
  assign byte_end = (dib == 2'd3);
  assign sec_end  = byte_end && (cnt == sec_last);
  assign buf_we   = (state == IDLE || state == COLLECT) && axiiv && (dcnt < MAX_DIBITS);
  assign axiov    = (state == PREAMBLE) || (state == HEADER) || (state == PAYLOAD) ||
                    (state == PAD) || (state == FCS);
  assign axiod    = axiov ? cur_byte[{dib, 1'b0} +: 2] : 2'b00;

  always_comb begin
    state_nxt = state;
    sec_last  = '0;
    cur_byte  = '0;
    case (state)
      IDLE:    if (axiiv) state_nxt = COLLECT;
      COLLECT: if (!axiiv) state_nxt = PREAMBLE;
      PREAMBLE: begin
        sec_last = CW'(7);
        cur_byte = (cnt == CW'(7)) ? 8'hD5 : 8'h55;
        if (sec_end) state_nxt = HEADER;
      end
      HEADER: begin
        sec_last = CW'(13);
        cur_byte = HDR[{4'd13 - hidx, 3'b000} +: 8];
        if (sec_end) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        sec_last = nbytes - CW'(1);
        cur_byte = pay_buf[cnt[AW-1:0]];
        if (sec_end) state_nxt = (nbytes < MIN_PAY) ? PAD : FCS;
      end
      PAD: begin
        sec_last = MIN_PAY - nbytes - CW'(1);
        if (sec_end) state_nxt = FCS;
      end
      FCS: begin
        sec_last = CW'(3);
        cur_byte = crc_out[{cnt[1:0], 3'b000} +: 8];
        if (sec_end) state_nxt = GAP;
      end
      GAP: begin
        sec_last = GAP_LAST;
        // A burst still in progress at the end of the gap is dropped whole.
        if (cnt == GAP_LAST && !axiiv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= '0;
      cnt   <= '0;
      dib   <= '0;
      crc   <= '1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, COLLECT: begin
          if (state == IDLE) begin
            cnt <= '0;
            dib <= '0;
            crc <= '1;
          end
          if (axiiv && dcnt < MAX_DIBITS) dcnt <= dcnt + CW'(1);
        end
        PREAMBLE, HEADER, PAYLOAD, PAD, FCS: begin
          dib <= dib + 2'd1;
          if (byte_end) cnt <= sec_end ? '0 : cnt + CW'(1);
          if (state == HEADER || state == PAYLOAD || state == PAD) crc <= crc2(crc, axiod);
        end
        GAP: begin
          dcnt <= '0;
          if (cnt != GAP_LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // First dibit of each byte clears the upper bits, so a trailing partial byte is zero-filled.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      if (dcnt[1:0] == 2'd0) pay_buf[dcnt[AW+1:2]] <= {6'b0, axiid};
      else pay_buf[dcnt[AW+1:2]][{dcnt[1:0], 1'b0} +: 2] <= axiid;
    end
  end

endmodule

// File: tb/tb_tether_frame_tx.sv
// Directed bench for tether_frame_tx: captures each transmitted frame and checks it against a byte-level frame model.
module tb_tether_frame_tx;

  logic       clk = 1'b0;
  logic       rst, axiiv, axiov;
  logic [1:0] axiid, axiod;

  int errors = 0;
  int checks = 0;
  int ncyc;
  logic [1:0] tx_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] fr_q[$];
  logic [7:0] exp_q[$];

  tether_frame_tx dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov), .axiod(axiod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic int count_bad(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++)
      if (i >= fr_q.size() || fr_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic push_bytes(input int n, input int start);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(start + i);
      for (int k = 0; k < 4; k++) tx_q.push_back(b[2*k +: 2]);
    end
  endtask

  task automatic send();
    foreach (tx_q[i]) begin
      axiiv = 1'b1;
      axiid = tx_q[i];
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
  endtask

  // Records every dibit while axiov is high; frame cycles [lo,hi) drive a stray burst.
  task automatic capture(input string name, input int lo, input int hi);
    int w = 0;
    int k = 0;
    logic [7:0] b = '0;
    fr_q.delete();
    while (!axiov && w < 400) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("%s start", name), 32'(axiov), 32'd1);
    while (axiov && k < 2000) begin
      b[2*(k%4) +: 2] = axiod;
      if (k % 4 == 3) begin
        fr_q.push_back(b);
        b = '0;
      end
      axiiv = (k >= lo && k < hi);
      axiid = 2'b11;
      @(negedge clk);
      k++;
    end
    axiiv = 1'b0;
    axiid = 2'b00;
    ncyc  = k;
  endtask

  task automatic expect_frame(input string name, input int gap_inj);
    logic [7:0]  hdr [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                              8'h69, 8'h69, 8'h5A, 8'h06, 8'h54, 8'h91, 8'h88, 8'hB5};
    logic [31:0] c;
    int busy = 0;
    int sz;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    while (exp_q.size() < 68) exp_q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_byte(c, exp_q[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    sz = exp_q.size();

    check($sformatf("%s len", name), 32'(ncyc), 32'(sz * 4));
    check($sformatf("%s preamble", name), 32'(count_bad(0, 8)), 32'd0);
    check($sformatf("%s header", name), 32'(count_bad(8, 22)), 32'd0);
    check($sformatf("%s payload", name), 32'(count_bad(22, sz - 4)), 32'd0);
    check($sformatf("%s fcs", name), 32'(count_bad(sz - 4, sz)), 32'd0);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < fr_q.size(); i++) c = crc_byte(c, fr_q[i]);
    check($sformatf("%s residue", name), c, 32'hDEBB20E3);

    for (int g = 0; g < 48; g++) begin
      axiiv = (g < gap_inj);
      axiid = 2'b11;
      if (axiov || axiod != 2'b00) busy++;
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
    check($sformatf("%s gap", name), 32'(busy), 32'd0);
  endtask

  task automatic quiet(input string name, input int n);
    int busy = 0;
    for (int i = 0; i < n; i++) begin
      if (axiov || axiod != 2'b00) busy++;
      @(negedge clk);
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (3) @(negedge clk);
    check("reset axiov", 32'(axiov), 32'd0);
    check("reset axiod", 32'(axiod), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Half byte: 10,01 -> 0x06
    tx_q = '{2'b10, 2'b01};
    pay_q = '{8'h06};
    send();
    capture("half", 0, 0);
    expect_frame("half", 0);

    // One byte: 01,10,10,01 -> 0x69
    tx_q = '{2'b01, 2'b10, 2'b10, 2'b01};
    pay_q = '{8'h69};
    send();
    capture("one", 0, 0);
    expect_frame("one", 0);

    // Two bytes of 0x55
    tx_q.delete();
    push_bytes(1, 8'h55);
    push_bytes(1, 8'h55);
    pay_q = '{8'h55, 8'h55};
    send();
    capture("two", 0, 0);
    expect_frame("two", 0);

    // 22 bytes of 0x55
    tx_q.delete();
    pay_q.delete();
    for (int i = 0; i < 22; i++) begin
      push_bytes(1, 8'h55);
      pay_q.push_back(8'h55);
    end
    send();
    capture("b22", 0, 0);
    expect_frame("b22", 0);

    // 60 ascending bytes, no pad
    tx_q.delete();
    pay_q.delete();
    push_bytes(60, 0);
    for (int i = 0; i < 60; i++) pay_q.push_back(8'(i));
    send();
    capture("b60", 0, 0);
    expect_frame("b60", 0);

    // 70 bytes offered, only the first 64 are kept
    tx_q.delete();
    pay_q.delete();
    push_bytes(70, 0);
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i));
    send();
    capture("cap", 0, 0);
    expect_frame("cap", 0);

    // Reset in the middle of the header
    tx_q = '{2'b01, 2'b10, 2'b10, 2'b01};
    send();
    w = 0;
    while (!axiov && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (50) @(negedge clk);
    check("mid header axiov", 32'(axiov), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort axiov", 32'(axiov), 32'd0);
    check("abort axiod", 32'(axiod), 32'd0);
    rst = 1'b0;
    quiet("after abort idle", 20);
    tx_q = '{2'b10, 2'b01};
    pay_q = '{8'h06};
    send();
    capture("post rst", 0, 0);
    expect_frame("post rst", 0);

    // Bursts during payload/pad and during gap are dropped
    tx_q = '{2'b01, 2'b10, 2'b10, 2'b01};
    pay_q = '{8'h69};
    send();
    capture("ovl", 88, 96);
    expect_frame("ovl", 10);
    quiet("no second frame", 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
